// File: rtl/ripple_count_sampler.sv
// Samples an asynchronous ripple counter into the clk domain, accepts a value once it
// has been steady for STABLE_CYCLES cycles, and reports value/delta/wrap over valid/ready.

module rcs_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else     ff <= {ff[STAGES-2:0], d};

  assign q = ff[STAGES-1];
endmodule

module ripple_count_sampler #(
  parameter int WIDTH         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 2,
  parameter int MAX_WAIT      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] cnt_in,
  input  logic             sample_req,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_count,
  output logic [WIDTH-1:0] out_delta,
  output logic             out_wrap,
  output logic             out_err
);
  localparam int SW = $clog2(STABLE_CYCLES + 1) + 1;
  localparam int WW = $clog2(MAX_WAIT + 1) + 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, HOLD = 2'd2} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] s, p, last_cap, last_cap_d, count_d, delta_d;
  logic [SW-1:0]    stab_cnt, stab_d;
  logic [WW-1:0]    wait_cnt, wait_d;
  logic             valid_d, wrap_d, err_d, stable_hit;

  for (genvar i = 0; i < WIDTH; i++) begin : g_sync
    rcs_sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (cnt_in[i]),
      .q   (s[i])
    );
  end

  assign busy       = (state == SETTLE) || (state == HOLD);
  assign stable_hit = (s == p) && (stab_cnt == STAB_LAST);

  always_comb begin
    state_d    = state;
    stab_d     = stab_cnt;
    wait_d     = wait_cnt;
    valid_d    = out_valid;
    count_d    = out_count;
    delta_d    = out_delta;
    wrap_d     = out_wrap;
    err_d      = out_err;
    last_cap_d = last_cap;
    case (state)
      IDLE: if (sample_req) begin
        state_d = SETTLE;
        stab_d  = '0;
        wait_d  = '0;
      end
      SETTLE: begin
        wait_d = wait_cnt + 1'b1;
        stab_d = (s == p) ? stab_cnt + 1'b1 : '0;
        // Timeout still captures so the consumer is never starved; err flags it.
        if (stable_hit || wait_cnt == WAIT_LAST) begin
          state_d    = HOLD;
          valid_d    = 1'b1;
          count_d    = s;
          delta_d    = s - last_cap;
          wrap_d     = s < last_cap;
          err_d      = !stable_hit;
          last_cap_d = s;
        end
      end
      HOLD: if (out_valid && out_ready) begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      p         <= '0;
      stab_cnt  <= '0;
      wait_cnt  <= '0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_delta <= '0;
      out_wrap  <= 1'b0;
      out_err   <= 1'b0;
      last_cap  <= '0;
    end else begin
      state     <= state_d;
      p         <= s;
      stab_cnt  <= stab_d;
      wait_cnt  <= wait_d;
      out_valid <= valid_d;
      out_count <= count_d;
      out_delta <= delta_d;
      out_wrap  <= wrap_d;
      out_err   <= err_d;
      last_cap  <= last_cap_d;
    end
  end
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Scoreboard bench for ripple_count_sampler: stimulus pushes predicted captures,
// a negedge monitor pops and compares them on every accepted transfer.

module tb_ripple_count_sampler;
  localparam int SYNC = 2, STAB = 2, MAXW = 16;

  typedef struct packed {
    logic [3:0] cnt;
    logic [3:0] delta;
    logic       wrap;
    logic       err;
  } exp_t;

  logic       clk = 1'b0, rst = 1'b1, sample_req = 1'b0, out_ready = 1'b1;
  logic [3:0] cnt_in = 4'hA;
  logic       busy, out_valid, out_wrap, out_err;
  logic [3:0] out_count, out_delta;

  int   n_checks = 0, n_fail = 0;
  exp_t exp_q[$];
  logic [3:0] last_m = 4'd0;

  ripple_count_sampler #(.WIDTH(4), .SYNC_STAGES(SYNC), .STABLE_CYCLES(STAB), .MAX_WAIT(MAXW)) dut (
    .clk(clk), .rst(rst), .cnt_in(cnt_in), .sample_req(sample_req), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
    .out_delta(out_delta), .out_wrap(out_wrap), .out_err(out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: delta is modular difference, wrap is a plain numeric comparison.
  task automatic push_exp(input logic [3:0] v, input logic err);
    exp_t e;
    e.cnt   = v;
    e.delta = 4'((int'(v) - int'(last_m) + 16) % 16);
    e.wrap  = (int'(v) < int'(last_m));
    e.err   = err;
    exp_q.push_back(e);
    last_m = v;
  endtask

  always @(negedge clk) begin : mon
    exp_t a, e;
    if (!rst && out_valid && out_ready) begin
      a = {out_count, out_delta, out_wrap, out_err};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_capture: got cnt=%0h delta=%0h wrap=%0b err=%0b, expected none",
                 a.cnt, a.delta, a.wrap, a.err);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_fail++;
          $display("FAIL capture: got cnt=%0h delta=%0h wrap=%0b err=%0b, expected cnt=%0h delta=%0h wrap=%0b err=%0b",
                   a.cnt, a.delta, a.wrap, a.err, e.cnt, e.delta, e.wrap, e.err);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 60) begin tick(); n++; end
    chk(nm, busy, 0);
  endtask

  // Steady value, request, then check out_valid rises exactly STAB edges after the request edge.
  task automatic capture(input logic [3:0] v);
    cnt_in = v;
    repeat (SYNC + 2) tick();
    push_exp(v, 1'b0);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("busy_after_req", busy, 1);
    for (int k = 1; k <= STAB; k++) begin
      tick();
      chk("latency", out_valid, (k == STAB) ? 1 : 0);
    end
    if (out_ready) wait_idle("return_idle");
  endtask

  initial begin
    exp_t hold_e;
    logic [3:0] v;
    int hold_it;

    // Reset with clock running and a nonzero counter
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_count", out_count, 0);
    chk("rst_delta", out_delta, 0);
    chk("rst_wrap", out_wrap, 0);
    chk("rst_err", out_err, 0);
    rst = 1'b0;
    tick();

    // Steady captures
    capture(4'd5);
    capture(4'd9);

    // Wrap
    capture(4'd14);
    capture(4'd3);

    // Equal consecutive captures
    capture(4'd3);

    // Glitching input: forced capture after MAXW settle cycles
    hold_it = 4 + MAXW - SYNC;
    for (int i = 0; i < 26; i++) begin
      cnt_in = i[0] ? 4'd8 : 4'd7;
      sample_req = (i == 4);
      if (i == 4) push_exp((hold_it % 2) ? 4'd8 : 4'd7, 1'b1);
      tick();
    end
    sample_req = 1'b0;
    wait_idle("glitch_idle");
    capture(4'd8);

    // Backpressure: outputs frozen, request ignored
    out_ready = 1'b0;
    capture(4'd11);
    hold_e = exp_q[exp_q.size()-1];
    for (int i = 0; i < 10; i++) begin
      cnt_in = 4'($urandom_range(0, 15));
      sample_req = 1'($urandom_range(0, 1));
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_frozen", {out_count, out_delta, out_wrap, out_err}, hold_e);
    end
    sample_req = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_valid_drop", out_valid, 0);
    chk("bp_idle", busy, 0);
    repeat (3) tick();
    chk("bp_no_queued_req", busy, 0);

    // Reset mid-SETTLE
    cnt_in = 4'd6;
    repeat (4) tick();
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("settle_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_settle_valid", out_valid, 0);
    chk("rst_settle_busy", busy, 0);
    last_m = 4'd0;
    tick();
    rst = 1'b0;

    // Reset mid-HOLD: expected capture is discarded
    out_ready = 1'b0;
    capture(4'd13);
    rst = 1'b1;
    #1;
    void'(exp_q.pop_back());
    last_m = 4'd0;
    chk("rst_hold_valid", out_valid, 0);
    chk("rst_hold_busy", busy, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    capture(4'd2);

    // Randomised captures
    for (int i = 0; i < 8; i++) begin
      v = 4'($urandom_range(0, 15));
      capture(v);
    end

    repeat (3) tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
